// File: rtl/fifo_pkg.sv
// Shared definitions for the asynchronous FIFO: skid-buffer occupancy encoding
// and Gray-to-binary conversion.
package fifo_pkg;

  localparam int GRAY_MAX_W = 32;

  typedef enum logic [1:0] {
    CNT_EMPTY = 2'd0,
    CNT_ONE   = 2'd1,
    CNT_TWO   = 2'd2
  } cnt_e;

  // Width-generic: callers zero-extend a narrower Gray code and truncate the result.
  // Leading zero bits of the Gray code become leading zero bits of the binary value.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer that carries the read-domain Gray pointer into wclk.
module sync_r2w #(
  parameter int W = 4
) (
  input  logic         wclk,
  input  logic         wrst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] wq1_q;
  logic [W-1:0] wq2_q;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wq1_q <= '0;
      wq2_q <= '0;
    end else begin
      wq1_q <= d_i;
      wq2_q <= wq1_q;
    end
  end

  assign q_o = wq2_q;

endmodule

// File: rtl/wr_ingress.sv
// Write-side ingress of the async FIFO: 2-entry skid buffer in front of the
// full-flag block, read-pointer synchronizer, and write-side fill level.
module wr_ingress
  import fifo_pkg::*;
#(
  parameter int addr_width   = 3,
  parameter int data_width   = 8,
  parameter int afull_thresh = 6
) (
  input  logic                  wclk,
  input  logic                  wrst_n,
  input  logic                  s_valid,
  input  logic [data_width-1:0] s_data,
  output logic                  s_ready,
  input  logic [addr_width:0]   rptr_gray,
  input  logic [addr_width:0]   wptr,
  input  logic                  wfull,
  output logic                  winc,
  output logic [data_width-1:0] wdata,
  output logic [addr_width:0]   wq2_rptr,
  output logic [addr_width:0]   wlevel,
  output logic                  walmost_full
);

  localparam int PW = addr_width + 1;
  localparam logic [PW-1:0] AFULL = PW'(afull_thresh);

  cnt_e                  cnt_q, cnt_d;
  logic [data_width-1:0] head_q, head_d;
  logic [data_width-1:0] tail_q, tail_d;
  logic                  s_ready_q;
  logic                  acc;
  logic                  pop;

  assign acc     = s_valid && s_ready_q;
  assign winc    = (cnt_q != CNT_EMPTY) && !wfull;
  assign pop     = winc;
  assign s_ready = s_ready_q;
  assign wdata   = head_q;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    tail_d = tail_q;
    case (cnt_q)
      CNT_EMPTY: begin
        if (acc) begin
          head_d = s_data;
          cnt_d  = CNT_ONE;
        end
      end
      CNT_ONE: begin
        case ({acc, pop})
          2'b10: begin
            tail_d = s_data;
            cnt_d  = CNT_TWO;
          end
          2'b01:   cnt_d  = CNT_EMPTY;
          2'b11:   head_d = s_data;
          default: cnt_d  = CNT_ONE;
        endcase
      end
      CNT_TWO: begin
        // s_ready is low here, so only a pop can occur.
        if (pop) begin
          head_d = tail_q;
          cnt_d  = CNT_ONE;
        end
      end
      default: cnt_d = CNT_EMPTY;
    endcase
  end

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      cnt_q     <= CNT_EMPTY;
      head_q    <= '0;
      tail_q    <= '0;
      s_ready_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      s_ready_q <= (cnt_d != CNT_TWO);
    end
  end

  sync_r2w #(.W(PW)) u_sync_r2w (
    .wclk   (wclk),
    .wrst_n (wrst_n),
    .d_i    (rptr_gray),
    .q_o    (wq2_rptr)
  );

  logic [PW-1:0] rbin;
  logic [PW-1:0] diff;
  logic [PW-1:0] wlevel_q;
  logic          walmost_q;

  // Modular subtraction covers pointer wrap through the MSB.
  assign rbin = PW'(gray2bin(GRAY_MAX_W'(wq2_rptr)));
  assign diff = wptr - rbin;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_q  <= '0;
      walmost_q <= 1'b0;
    end else begin
      wlevel_q  <= diff;
      walmost_q <= (diff >= AFULL);
    end
  end

  assign wlevel       = wlevel_q;
  assign walmost_full = walmost_q;

endmodule
